// File: rtl/sub32_seq.sv
// Chunk-serial subtractor: diff = a - b, CHUNK_W bits per cycle, LSB chunk first; result valid N_CHUNK cycles after accept.
// Valid/ready on both sides: operands are accepted only in IDLE, and the result is held in DONE until ready_i.
module sub32_seq #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] diff_o,
    output logic              borrow_o,
    output logic              zero_o
);

    localparam int N_CHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W   = $clog2(N_CHUNK) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNK - 1);

    generate
        if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
            $error("sub32_seq: DATA_W must be a multiple of CHUNK_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_borrow;
    logic [DATA_W-1:0]   r_diff;
    logic                r_borrow_out;
    logic                r_zero;

    logic                w_accept;
    logic                w_last;
    logic [CHUNK_W:0]    w_sub;
    logic                w_bout;
    logic [DATA_W-1:0]   w_acc_nxt;

    assign w_accept = valid_i && (r_state == S_IDLE);
    assign w_last   = (r_cnt == LAST_CNT);

    // Operands shift right so the current chunk is always the low CHUNK_W bits.
    assign w_sub  = {1'b0, r_a[CHUNK_W-1:0]} - {1'b0, r_b[CHUNK_W-1:0]} - (CHUNK_W+1)'(r_borrow);
    assign w_bout = w_sub[CHUNK_W];

    // Result chunks enter at the top; after N_CHUNK shifts chunk 0 sits at the bottom.
    always_comb begin
        w_acc_nxt = r_acc >> CHUNK_W;
        w_acc_nxt[DATA_W-1 -: CHUNK_W] = w_sub[CHUNK_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a      <= a_i;
                r_b      <= b_i;
                r_borrow <= 1'b0;
                r_cnt    <= '0;
            end else if (r_state == S_RUN) begin
                r_a      <= r_a >> CHUNK_W;
                r_b      <= r_b >> CHUNK_W;
                r_acc    <= w_acc_nxt;
                r_borrow <= w_bout;
                r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
                // Visible outputs change only once the whole difference is known.
                if (w_last) begin
                    r_diff       <= w_acc_nxt;
                    r_borrow_out <= w_bout;
                    r_zero       <= (w_acc_nxt == '0);
                end
            end
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign valid_o  = (r_state == S_DONE);
    assign diff_o   = r_diff;
    assign borrow_o = r_borrow_out;
    assign zero_o   = r_zero;

endmodule

// File: tb/tb_sub32_seq.sv
// Bench for sub32_seq: directed and random operands, queued expectations checked by an independent monitor.
module tb_sub32_seq;

    localparam int DATA_W  = 32;
    localparam int CHUNK_W = 8;
    localparam int N_CHUNK = DATA_W / CHUNK_W;

    logic              clk;
    logic              rst;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] diff_o;
    logic              borrow_o;
    logic              zero_o;

    typedef struct {
        logic [DATA_W-1:0] diff;
        logic              borrow;
        logic              zero;
        int                acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   cyc;
    int   rdy_mode;

    sub32_seq #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .diff_o   (diff_o),
        .borrow_o (borrow_o),
        .zero_o   (zero_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting on the DUT (cycle %0d)", name, cyc);
    endtask

    // Reference: plain modular arithmetic and unsigned comparison.
    function automatic exp_t model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input int c);
        exp_t e;
        e.diff    = a - b;
        e.borrow  = (a < b);
        e.zero    = (a == b);
        e.acc_cyc = c;
        return e;
    endfunction

    // Consumer-side ready: 0 = held low, 1 = held high, other = random.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       ready_i = 1'b0;
                1:       ready_i = 1'b1;
                default: ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: latency, result values, hold under back-pressure, hold through IDLE/RUN.
    logic              mon_pv;
    logic              mon_phs;
    logic              mon_have_last;
    logic [DATA_W+1:0] mon_cur;
    logic [DATA_W+1:0] mon_prev;
    logic [DATA_W+1:0] mon_last;
    exp_t              mon_e;

    initial begin
        mon_pv = 1'b0;
        mon_phs = 1'b0;
        mon_have_last = 1'b0;
        mon_prev = '0;
        mon_last = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_pv = 1'b0;
                mon_phs = 1'b0;
                mon_have_last = 1'b0;
            end else begin
                mon_cur = {diff_o, borrow_o, zero_o};
                if (valid_o && !mon_pv) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_valid: valid_o high with nothing outstanding (cycle %0d)", cyc);
                    end else begin
                        check("latency", 64'(cyc), 64'(sb[0].acc_cyc + N_CHUNK));
                    end
                end
                if (valid_o && mon_pv && !mon_phs)
                    check("hold_in_done", 64'(mon_cur), 64'(mon_prev));
                if (!valid_o && mon_have_last)
                    check("hold_outside_done", 64'(mon_cur), 64'(mon_last));
                if (valid_o && ready_i && sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("diff", 64'(diff_o), 64'(mon_e.diff));
                    check("borrow", 64'(borrow_o), 64'(mon_e.borrow));
                    check("zero", 64'(zero_o), 64'(mon_e.zero));
                    mon_last = mon_cur;
                    mon_have_last = 1'b1;
                end
                mon_phs = valid_o && ready_i;
                mon_pv = valid_o;
                mon_prev = mon_cur;
            end
        end
    end

    // Entered and left at posedge+1; the expectation is queued on the cycle the handshake occurs.
    task automatic do_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        int  t;
        bit  done;
        t = 0;
        done = 1'b0;
        valid_i = 1'b1;
        a_i = a;
        b_i = b;
        while (!done) begin
            @(negedge clk);
            if (ready_o) begin
                sb.push_back(model(a, b, cyc + 1));
                done = 1'b1;
            end else begin
                t++;
                if (t > 200) begin
                    timeout_fail("accept");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (t >= 0) begin
            @(negedge clk);
            if (sb.size() == 0 && ready_o) begin
                t = -1;
            end else begin
                t++;
                if (t > 300) begin
                    timeout_fail("drain");
                    t = -1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready_o"}, 64'(ready_o), 64'(1));
        check({tag, "_valid_o"}, 64'(valid_o), 64'(0));
        check({tag, "_diff_o"}, 64'(diff_o), 64'(0));
        check({tag, "_borrow_o"}, 64'(borrow_o), 64'(0));
        check({tag, "_zero_o"}, 64'(zero_o), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;
        int                t;
        n_vec = 0;
        n_err = 0;
        rdy_mode = 1;
        rst = 1'b1;
        valid_i = 1'b0;
        a_i = '0;
        b_i = '0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic, wrap, cross-chunk borrow, equal, MSB boundary.
        do_op(32'd5, 32'd3);               wait_drain();
        do_op(32'd0, 32'd1);               wait_drain();
        do_op(32'h0000_0100, 32'h0000_0001); wait_drain();
        do_op(32'h1234_5678, 32'h1234_5678); wait_drain();
        do_op(32'h8000_0000, 32'h7FFF_FFFF); wait_drain();

        // Back-pressure: DONE held five cycles while valid_i pulses are refused.
        @(negedge clk);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        do_op(32'hDEAD_BEEF, 32'h0000_BEEF);
        t = 0;
        while (!valid_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!valid_o) timeout_fail("bp_valid");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            valid_i = ~valid_i;
            a_i = $urandom;
            b_i = $urandom;
            @(negedge clk);
            check("bp_ready_o", 64'(ready_o), 64'(0));
            check("bp_valid_o", 64'(valid_o), 64'(1));
        end
        rdy_mode = 1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        check("release_ready_o_same_cycle", 64'(ready_o), 64'(0));
        @(negedge clk);
        check("release_ready_o_next", 64'(ready_o), 64'(1));
        check("release_valid_o_next", 64'(valid_o), 64'(0));
        check("release_queue_empty", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;

        // Asynchronous reset in the second RUN cycle discards the operation.
        do_op(32'h1111_1111, 32'h2222_2222);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        do_op(32'd7, 32'd9);
        wait_drain();

        // Random traffic, back-to-back where the DUT allows, with random consumer stalls.
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = ra;
                1:       ra = '0;
                2:       rb = 32'hFFFF_FFFF;
                3:       ra = rb + 32'd1;
                4:       rb = ra + 32'd1;
                default: ;
            endcase
            do_op(ra, rb);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
